// File: rtl/ula_pkg.sv
// ula_pkg -- shared opcode and FSM state types for the sequential ALU (ula_seq).
package ula_pkg;

    // Opcode encoding, as seen on the 3-bit op input.
    typedef enum logic [2:0] {
        ULA_ADD = 3'd0,
        ULA_SUB = 3'd1,
        ULA_AND = 3'd2,
        ULA_OR  = 3'd3,
        ULA_XOR = 3'd4,
        ULA_SLL = 3'd5,
        ULA_SRL = 3'd6,
        ULA_MUL = 3'd7
    } ula_op_e;

    // Control FSM states. BUSY is only reachable when the multiplier is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ula_state_e;

endpackage : ula_pkg

// File: rtl/ula_mul.sv
// ula_mul -- iterative unsigned shift-add multiplier, one partial product per cycle.
// start loads the operands; done pulses during the WIDTH-th iteration, and product
// then shows the final (combinationally completed) result for the parent to capture.
module ula_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done    = busy_q && (cnt_q == CW'(1));
    assign product = acc_d;

    // Load operands on start, then add/shift one multiplier bit per cycle.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are plain registers, not a memory, so all of them are cleared;
            // a reset mid-multiply must leave no stale partial product behind.
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, A};
            acc_q    <= '0;
            mplier_q <= B;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule : ula_mul

// File: rtl/ula_seq.sv
// ula_seq -- sequential ALU with valid/ready handshakes on operands and result.
// Single-cycle ops finish on the accept edge; MUL iterates WIDTH cycles in ula_mul.
// Build option: define ULA_SEQ_MUL_EN to include the multiplier. Without it MUL
// completes immediately with C=0, zero=1 and err=1.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    ula_state_e       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    ula_op_e          op_e;
    logic             accept;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_c;
    logic             alu_carry;
    logic             alu_ovf;

    assign op_e      = ula_op_e'(op);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign add_w     = {1'b0, A} + {1'b0, B};
    assign sub_w     = {1'b0, A} - {1'b0, B};
    assign shamt     = B[SHW-1:0];

`ifdef ULA_SEQ_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    ula_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    // Single-cycle datapath: result, carry/borrow and signed overflow for ops 0..6.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        alu_c     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_e)
            ULA_ADD: begin
                alu_c     = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
                alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
            end
            ULA_SUB: begin
                alu_c     = sub_w[WIDTH-1:0];
                alu_carry = sub_w[WIDTH];  // borrow: A < B unsigned
                alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
            end
            ULA_AND: alu_c = A & B;
            ULA_OR:  alu_c = A | B;
            ULA_XOR: alu_c = A ^ B;
            ULA_SLL: alu_c = A << shamt;
            ULA_SRL: alu_c = A >> shamt;
            default: ;
        endcase
    end

    // Next state and result registers: drain DONE, finish MUL, then let a new accept override.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
`ifdef ULA_SEQ_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            DONE: if (out_ready) state_d = IDLE;
`ifdef ULA_SEQ_MUL_EN
            BUSY: if (mul_done) begin
                state_d = DONE;
                c_d     = mul_prod[WIDTH-1:0];
                zero_d  = (mul_prod[WIDTH-1:0] == '0);
                carry_d = |mul_prod[2*WIDTH-1:WIDTH];
                ovf_d   = 1'b0;
                err_d   = 1'b0;
            end
`endif
            default: ;
        endcase

        // accept is only possible from IDLE or from a DONE being drained this cycle.
        if (accept) begin
            if (op_e == ULA_MUL) begin
`ifdef ULA_SEQ_MUL_EN
                state_d   = BUSY;
                mul_start = 1'b1;
`else
                state_d = DONE;
                c_d     = '0;
                zero_d  = 1'b1;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                err_d   = 1'b1;
`endif
            end else begin
                state_d = DONE;
                c_d     = alu_c;
                zero_d  = (alu_c == '0);
                carry_d = alu_carry;
                ovf_d   = alu_ovf;
                err_d   = 1'b0;
            end
        end
    end

    // State and registered result/flags; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign C     = c_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign err   = err_q;

endmodule : ula_seq
